// File: rtl/inst_fetch_queue.sv
// Two-wide instruction fetch queue: tags ROM bundles with PCs, buffers them
// in a circular store and hands up to two oldest entries to decode per cycle.
module inst_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_fetch_valid,
    input  logic [31:0]                    i_fetch_insts [2],
    output logic                           o_fetch_ready,
    output logic [1:0]                     o_dec_valid,
    output logic [31:0]                    o_dec_insts [2],
    output logic [31:0]                    o_dec_pc [2],
    input  logic [1:0]                     i_dec_take,
    input  logic                           i_flush,
    input  logic [31:0]                    i_flush_pc,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_eos
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          eos_q, eos_d;
    logic [31:0]   next_pc_q, next_pc_d;

    logic          enq_en;
    logic          wr0, wr1;
    logic [1:0]    n_wr;
    logic [1:0]    take_req, avail, take_eff;
    logic [PW-1:0] tail_p1, head_p1;

    assign o_fetch_ready = (count_q <= CW'(DEPTH - 2));
    assign enq_en        = i_fetch_valid && o_fetch_ready && !i_flush;

    // A zero word ends the stream: it and everything after it in program order is dropped.
    assign wr0  = enq_en && !eos_q && (i_fetch_insts[0] != 32'h0);
    assign wr1  = wr0 && (i_fetch_insts[1] != 32'h0);
    assign n_wr = {1'b0, wr0} + {1'b0, wr1};

    assign tail_p1 = tail_q + PW'(1);
    assign head_p1 = head_q + PW'(1);

    always_comb begin
        take_req = 2'd0;
        avail    = 2'd0;
        if (i_dec_take == 2'd1)      take_req = 2'd1;
        else if (i_dec_take != 2'd0) take_req = 2'd2;
        if (count_q >= CW'(2))       avail = 2'd2;
        else if (count_q == CW'(1))  avail = 2'd1;
        take_eff = (take_req < avail) ? take_req : avail;
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        eos_d     = eos_q;
        next_pc_d = next_pc_q;
        if (i_flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            eos_d     = 1'b0;
            next_pc_d = i_flush_pc;
        end else begin
            head_d    = head_q + PW'(take_eff);
            tail_d    = tail_q + PW'(n_wr);
            count_d   = count_q + CW'(n_wr) - CW'(take_eff);
            next_pc_d = next_pc_q + {28'h0, n_wr, 2'b00};
            if (enq_en && !eos_q &&
                ((i_fetch_insts[0] == 32'h0) || (i_fetch_insts[1] == 32'h0)))
                eos_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            eos_q     <= 1'b0;
            next_pc_q <= RESET_PC;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            eos_q     <= eos_d;
            next_pc_q <= next_pc_d;
        end
    end

    // Storage is cleared on reset so unused decode slots never read back X.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (wr0) begin
                inst_q[tail_q] <= i_fetch_insts[0];
                pc_q[tail_q]   <= next_pc_q;
            end
            if (wr1) begin
                inst_q[tail_p1] <= i_fetch_insts[1];
                pc_q[tail_p1]   <= next_pc_q + 32'd4;
            end
        end
    end

    assign o_dec_valid    = {count_q >= CW'(2), count_q >= CW'(1)};
    assign o_dec_insts[0] = inst_q[head_q];
    assign o_dec_insts[1] = inst_q[head_p1];
    assign o_dec_pc[0]    = pc_q[head_q];
    assign o_dec_pc[1]    = pc_q[head_p1];
    assign o_count        = count_q;
    assign o_eos          = eos_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed-vector bench for inst_fetch_queue with hand-computed expectations.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_insts [2];
    logic        fetch_ready;
    logic [1:0]  dec_valid;
    logic [31:0] dec_insts [2];
    logic [31:0] dec_pc [2];
    logic [1:0]  dec_take;
    logic        flush;
    logic [31:0] flush_pc;
    logic [3:0]  count;
    logic        eos;

    int n_vec = 0;
    int n_err = 0;

    inst_fetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fetch_valid (fetch_valid),
        .i_fetch_insts (fetch_insts),
        .o_fetch_ready (fetch_ready),
        .o_dec_valid   (dec_valid),
        .o_dec_insts   (dec_insts),
        .o_dec_pc      (dec_pc),
        .i_dec_take    (dec_take),
        .i_flush       (flush),
        .i_flush_pc    (flush_pc),
        .o_count       (count),
        .o_eos         (eos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
        fetch_valid    = v;
        fetch_insts[0] = a;
        fetch_insts[1] = b;
        dec_take       = t;
    endtask

    task automatic idle();
        bundle(1'b0, 32'h0, 32'h0, 2'd0);
        flush = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_valid"}, 32'(dec_valid), 32'd0);
        check({tag, "_eos"},   32'(eos), 32'd0);
        check({tag, "_ready"}, 32'(fetch_ready), 32'd1);
        check({tag, "_inst0"}, dec_insts[0], 32'h0);
        check({tag, "_pc1"},   dec_pc[1], 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        flush_pc = 32'h0;
        idle();
        step();
        step();
        check_reset_state("rst");

        // Two bundles, no dequeue
        rst_n = 1'b1;
        bundle(1'b1, 32'h00500093, 32'h00A00113, 2'd0);
        step();
        bundle(1'b1, 32'h002081B3, 32'h40208233, 2'd0);
        step();
        idle();
        check("b2_count", 32'(count), 32'd4);
        check("b2_pc0", dec_pc[0], 32'h0);
        check("b2_pc1", dec_pc[1], 32'h4);
        check("b2_inst0", dec_insts[0], 32'h00500093);
        check("b2_inst1", dec_insts[1], 32'h00A00113);
        check("b2_valid", 32'(dec_valid), 32'd3);
        dec_take = 2'd2;
        step();
        check("b2_take_count", 32'(count), 32'd2);
        check("b2_take_inst0", dec_insts[0], 32'h002081B3);
        check("b2_take_pc1", dec_pc[1], 32'hC);

        // Flush back to PC 0 for the fill test
        flush = 1'b1;
        flush_pc = 32'h0;
        step();
        idle();
        check("fl0_count", 32'(count), 32'd0);

        // Fill to DEPTH with take=0
        for (int k = 0; k < 4; k++) begin
            bundle(1'b1, 32'h1000 + 32'(2*k), 32'h1001 + 32'(2*k), 2'd0);
            step();
            check("fill_count", 32'(count), 32'(2*k + 2));
            check("fill_ready", 32'(fetch_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        bundle(1'b1, 32'hDEAD0001, 32'hDEAD0002, 2'd0);
        step();
        check("full_ignore_count", 32'(count), 32'd8);
        check("full_ignore_inst0", dec_insts[0], 32'h1000);
        bundle(1'b1, 32'hDEAD0003, 32'hDEAD0004, 2'd1);
        step();
        check("seven_count", 32'(count), 32'd7);
        check("seven_ready", 32'(fetch_ready), 32'd0);
        idle();
        for (int h = 1; h < 8; h += 2) begin
            check("drain_pc0", dec_pc[0], 32'(4*h));
            check("drain_inst0", dec_insts[0], 32'h1000 + 32'(h));
            if (h < 7) check("drain_pc1", dec_pc[1], 32'(4*h + 4));
            else       check("drain_valid1", 32'(dec_valid), 32'd1);
            dec_take = 2'd2;
            step();
            check("drain_count", 32'(count), (h < 7) ? 32'(6 - h) : 32'd0);
        end
        check("drained_valid", 32'(dec_valid), 32'd0);

        // Steady state: pointers wrap, next_pc is 0x20
        bundle(1'b1, 32'h3000, 32'h3001, 2'd0);
        step();
        for (int i = 0; i < 20; i++) begin
            bundle(1'b1, 32'h2000 + 32'(2*i), 32'h2001 + 32'(2*i), 2'd2);
            step();
            check("ss_count", 32'(count), 32'd2);
            check("ss_pc0", dec_pc[0], 32'h28 + 32'(8*i));
            check("ss_pc1", dec_pc[1], 32'h2C + 32'(8*i));
            check("ss_inst1", dec_insts[1], 32'h2001 + 32'(2*i));
        end

        // take=3 with four entries; next_pc is 0xC8
        bundle(1'b1, 32'h4000, 32'h4001, 2'd0);
        step();
        check("t3_pre_count", 32'(count), 32'd4);
        bundle(1'b0, 32'h0, 32'h0, 2'd3);
        step();
        check("t3_count", 32'(count), 32'd2);
        check("t3_pc0", dec_pc[0], 32'hC8);

        // End of stream
        bundle(1'b1, 32'h00100093, 32'h00000000, 2'd0);
        step();
        check("eos_count", 32'(count), 32'd3);
        check("eos_flag", 32'(eos), 32'd1);
        check("eos_ready", 32'(fetch_ready), 32'd1);
        bundle(1'b1, 32'h00200113, 32'h00300193, 2'd0);
        step();
        check("eos_drop_count", 32'(count), 32'd3);
        bundle(1'b0, 32'h0, 32'h0, 2'd2);
        step();
        check("eos_head_pc", dec_pc[0], 32'hD0);
        check("eos_head_inst", dec_insts[0], 32'h00100093);
        check("eos_head_count", 32'(count), 32'd1);

        // Flush to 0x40, build five entries
        idle();
        flush = 1'b1;
        flush_pc = 32'h40;
        step();
        flush = 1'b0;
        check("fl1_eos", 32'(eos), 32'd0);
        bundle(1'b1, 32'h5000, 32'h5001, 2'd0);
        step();
        check("fl1_pc0", dec_pc[0], 32'h40);
        bundle(1'b1, 32'h5002, 32'h5003, 2'd0);
        step();
        bundle(1'b1, 32'h5004, 32'h0, 2'd0);
        step();
        check("fl5_count", 32'(count), 32'd5);
        bundle(1'b1, 32'h6000, 32'h6001, 2'd2);
        flush = 1'b1;
        flush_pc = 32'h100;
        step();
        flush = 1'b0;
        check("fl2_count", 32'(count), 32'd0);
        check("fl2_eos", 32'(eos), 32'd0);
        check("fl2_valid", 32'(dec_valid), 32'd0);
        bundle(1'b1, 32'h11, 32'h22, 2'd0);
        step();
        check("fl2_pc0", dec_pc[0], 32'h100);
        check("fl2_pc1", dec_pc[1], 32'h104);
        check("fl2_inst1", dec_insts[1], 32'h22);

        // Mid-stream reset
        bundle(1'b1, 32'h33, 32'h44, 2'd0);
        rst_n = 1'b0;
        step();
        check_reset_state("mrst");
        rst_n = 1'b1;
        bundle(1'b1, 32'h55, 32'h66, 2'd0);
        step();
        idle();
        check("mrst_pc0", dec_pc[0], 32'h0);
        check("mrst_pc1", dec_pc[1], 32'h4);
        check("mrst_count", 32'(count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
